// File: rtl/alu_serial_seq.sv
// alu_serial_seq: bit-serial sequencer around a 1-bit ALU slice.
// It accepts a WIDTH-bit operand pair and an op code over a valid/ready
// handshake. It evaluates one bit per clock, LSB first, and then presents
// the assembled result over a second valid/ready handshake.
//
// Optional feature: define ALU_SERIAL_ZERO_FLAG_EN to add the `zero` output.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   upstream operands/op valid
//   in_ready   block can accept an operation (IDLE)
//   a, b       WIDTH-bit operands
//   op         00 AND, 01 OR, 10 XOR, 11 ADD
//   out_valid  result/cout valid (DONE)
//   out_ready  downstream accepts the result
//   result     assembled WIDTH-bit result
//   cout       carry out of the MSB, ADD only
//   busy       high in RUN or DONE
//   zero       (ALU_SERIAL_ZERO_FLAG_EN) result==0, valid with out_valid
module alu_serial_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             busy
`ifdef ALU_SERIAL_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_ADD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_sh_q, a_sh_d;
    logic [WIDTH-1:0]  b_sh_q, b_sh_d;
    logic [1:0]        op_q, op_d;
    logic              carry_q, carry_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              cout_q, cout_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
    logic              zero_acc_q, zero_acc_d;
    logic              zero_q, zero_d;
`endif

    logic              r_bit;
    logic              carry_nxt;

    // 1-bit ALU slice on the current LSBs
    always_comb begin
        r_bit     = 1'b0;
        carry_nxt = 1'b0;
        case (op_q)
            OP_AND: r_bit = a_sh_q[0] & b_sh_q[0];
            OP_OR:  r_bit = a_sh_q[0] | b_sh_q[0];
            OP_XOR: r_bit = a_sh_q[0] ^ b_sh_q[0];
            OP_ADD: begin
                r_bit     = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
                carry_nxt = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q)
                          | (b_sh_q[0] & carry_q);
            end
            default: r_bit = 1'b0;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        a_sh_d     = a_sh_q;
        b_sh_d     = b_sh_q;
        op_d       = op_q;
        carry_d    = carry_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        cout_d     = cout_q;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
        zero_acc_d = zero_acc_q;
        zero_d     = zero_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // in_ready is high throughout IDLE, so in_valid alone marks a transfer
                if (in_valid) begin
                    a_sh_d     = a;
                    b_sh_d     = b;
                    op_d       = op;
                    carry_d    = 1'b0;
                    cnt_d      = '0;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
                    zero_acc_d = 1'b0;
`endif
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                carry_d  = carry_nxt;
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                result_d = {r_bit, result_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CNT_W'(1);
`ifdef ALU_SERIAL_ZERO_FLAG_EN
                zero_acc_d = zero_acc_q | r_bit;
`endif
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    cout_d  = carry_nxt;
                    state_d = ST_DONE;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
                    zero_d  = ~(zero_acc_q | r_bit);
`endif
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
                    zero_d  = 1'b0;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            op_q        <= 2'b00;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            result_q    <= '0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
            zero_acc_q  <= 1'b0;
            zero_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            op_q        <= op_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            cout_q      <= cout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
            zero_acc_q  <= zero_acc_d;
            zero_q      <= zero_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign result    = result_q;
    assign cout      = cout_q;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
    assign zero      = zero_q;
`endif

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed self-checking bench for alu_serial_seq at WIDTH=8.
module tb_alu_serial_seq;

    localparam int unsigned WIDTH = 8;
    localparam int MAX_WAIT = 40;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             busy;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
    logic             zero;
`endif

    int total;
    int bad;

    alu_serial_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .busy      (busy)
`ifdef ALU_SERIAL_ZERO_FLAG_EN
        ,
        .zero      (zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs are driven and outputs sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one operation; returns after the accept edge.
    task automatic issue(input logic [7:0] xa, input logic [7:0] xb, input logic [1:0] xop);
        a        = xa;
        b        = xb;
        op       = xop;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a        = 8'hC3;
        b        = 8'h5A;
        op       = 2'b01;
    endtask

    // Count edges after accept until out_valid, bounded.
    task automatic wait_out(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < MAX_WAIT) begin
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b want 1 0 0",
                     in_ready, out_valid, busy);
        end
        total++;
        if (result !== 8'h00 || cout !== 1'b0) begin
            bad++;
            $display("FAIL reset_data: result=%h cout=%b want 00 0", result, cout);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_and();
        int lat;
        out_ready = 1'b1;
        issue(8'hF0, 8'h3C, 2'b00);
        total++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL and_run_flags: busy=%b in_ready=%b want 1 0", busy, in_ready);
        end
        wait_out(lat);
        total++;
        if (lat !== 8) begin
            bad++;
            $display("FAIL and_latency: got %0d want 8", lat);
        end
        total++;
        if (result !== 8'h30 || cout !== 1'b0) begin
            bad++;
            $display("FAIL and_result: result=%h cout=%b want 30 0", result, cout);
        end
        step();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL and_to_idle: out_valid=%b in_ready=%b busy=%b want 0 1 0",
                     out_valid, in_ready, busy);
        end
        total++;
        if (result !== 8'h30) begin
            bad++;
            $display("FAIL idle_hold: result=%h want 30", result);
        end
    endtask

    task automatic test_op_sweep();
        logic [7:0] va  [4] = '{8'hAA, 8'h0F, 8'hFF, 8'h12};
        logic [7:0] vb  [4] = '{8'hFF, 8'hA0, 8'h01, 8'h34};
        logic [1:0] vop [4] = '{2'b10, 2'b01, 2'b11, 2'b11};
        logic [7:0] vr  [4] = '{8'h55, 8'hAF, 8'h00, 8'h46};
        logic       vc  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue(va[i], vb[i], vop[i]);
            wait_out(lat);
            total++;
            if (lat !== 8 || result !== vr[i] || cout !== vc[i]) begin
                bad++;
                $display("FAIL sweep_%0d: lat=%0d result=%h cout=%b want 8 %h %b",
                         i, lat, result, cout, vr[i], vc[i]);
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready = 1'b0;
        issue(8'h7F, 8'h01, 2'b11);
        wait_out(lat);
        total++;
        if (lat !== 8 || result !== 8'h80 || cout !== 1'b0) begin
            bad++;
            $display("FAIL bp_first: lat=%0d result=%h cout=%b want 8 80 0", lat, result, cout);
        end
        a        = 8'h13;
        b        = 8'h36;
        op       = 2'b00;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 8'h80 || cout !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold_%0d: out_valid=%b in_ready=%b result=%h cout=%b want 1 0 80 0",
                         i, out_valid, in_ready, result, cout);
            end
        end
        out_ready = 1'b1;
        step();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
        step();
        in_valid = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL bp_new_accept: busy=%b want 1", busy);
        end
        wait_out(lat);
        total++;
        if (lat !== 8 || result !== 8'h12) begin
            bad++;
            $display("FAIL bp_second: lat=%0d result=%h want 8 12", lat, result);
        end
        step();
    endtask

    task automatic test_reset_mid_run();
        int seen;
        out_ready = 1'b1;
        issue(8'hFF, 8'hFF, 2'b11);
        step();
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
            result !== 8'h00 || cout !== 1'b0) begin
            bad++;
            $display("FAIL midrun_reset: in_ready=%b out_valid=%b busy=%b result=%h cout=%b want 1 0 0 00 0",
                     in_ready, out_valid, busy, result, cout);
        end
        seen = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (out_valid === 1'b1 || busy === 1'b1) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL midrun_no_output: active cycles=%0d want 0", seen);
        end
    endtask

`ifdef ALU_SERIAL_ZERO_FLAG_EN
    task automatic test_zero();
        int lat;
        out_ready = 1'b1;
        issue(8'h55, 8'hAA, 2'b00);
        wait_out(lat);
        total++;
        if (lat !== 8 || result !== 8'h00 || zero !== 1'b1) begin
            bad++;
            $display("FAIL zero_set: lat=%0d result=%h zero=%b want 8 00 1", lat, result, zero);
        end
        step();
        issue(8'h01, 8'h00, 2'b01);
        wait_out(lat);
        total++;
        if (lat !== 8 || result !== 8'h01 || zero !== 1'b0) begin
            bad++;
            $display("FAIL zero_clear: lat=%0d result=%h zero=%b want 8 01 0", lat, result, zero);
        end
        step();
    endtask
`endif

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        op        = 2'b00;
        #1;
        test_reset();
        test_and();
        test_op_sweep();
        test_backpressure();
        test_reset_mid_run();
`ifdef ALU_SERIAL_ZERO_FLAG_EN
        test_zero();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
